// File: rtl/regfile_arb_pkg.sv
// Shared widths, well-known register numbers and the decision encoding
// used by the regfile write-port arbiter.
package regfile_arb_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_W     = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO    = 5'd0;
    localparam logic [REG_ADDR_W-1:0] REG_SCORE   = 5'd1;
    localparam logic [REG_ADDR_W-1:0] REG_RSTATUS = 5'd30;

    // Only the score and status registers are open to external writers.
    localparam logic [DATA_W-1:0] EXT_WRITE_MASK_DEFAULT = 32'h4000_0002;

    typedef enum logic [1:0] {
        SRC_IDLE = 2'd0,
        SRC_PROC = 2'd1,
        SRC_EXT  = 2'd2
    } wr_src_e;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of the processor writeback, external requester and regfile-side
// signals of the write-port arbiter.
interface regfile_write_arbiter_if #(
    parameter int NUM_EXT = 3
);
    import regfile_arb_pkg::*;

    logic                            wb_en;
    logic [REG_ADDR_W-1:0]           wb_reg;
    logic [DATA_W-1:0]               wb_data;
    logic [NUM_EXT-1:0]              ext_req;
    logic [REG_ADDR_W*NUM_EXT-1:0]   ext_reg;
    logic [DATA_W*NUM_EXT-1:0]       ext_data;
    logic [NUM_EXT-1:0]              ext_ack;
    logic                            proc_stall;
    logic                            ctrl_writeEnable;
    logic [REG_ADDR_W-1:0]           ctrl_writeReg;
    logic [DATA_W-1:0]               data_writeReg;
    logic                            err_sticky;

    modport master (
        output wb_en, wb_reg, wb_data, ext_req, ext_reg, ext_data,
        input  ext_ack, proc_stall, ctrl_writeEnable, ctrl_writeReg,
               data_writeReg, err_sticky
    );

    modport slave (
        input  wb_en, wb_reg, wb_data, ext_req, ext_reg, ext_data,
        output ext_ack, proc_stall, ctrl_writeEnable, ctrl_writeReg,
               data_writeReg, err_sticky
    );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first eligible requester at or after
// the pointer, wrapping to index 0.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     elig,
    input  logic [PTR_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] next_ptr
);

    // Upper pass covers [ptr, N-1]; the lower pass only fires when that found nothing.
    always_comb begin
        logic found;
        grant    = '0;
        next_ptr = ptr;
        found    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (en && !found && elig[i] && (i >= int'(ptr))) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                next_ptr = (i == N - 1) ? '0 : PTR_W'(i + 1);
            end else begin
                found = found;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (en && !found && elig[i]) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                next_ptr = (i == N - 1) ? '0 : PTR_W'(i + 1);
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the regfile write port between processor writeback and NUM_EXT
// external writers. REGFILE_ARB_PROTECT_EN enables EXT_WRITE_MASK filtering.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int          NUM_EXT        = 3,
    parameter int          STARVE_LIMIT   = 4,
    parameter logic [31:0] EXT_WRITE_MASK = EXT_WRITE_MASK_DEFAULT
) (
    input logic                    clock,
    input logic                    ctrl_reset,
    regfile_write_arbiter_if.slave bus
);

    localparam int PTR_W = (NUM_EXT > 1) ? $clog2(NUM_EXT) : 1;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);

    logic [NUM_EXT-1:0]    ext_ack_r, ack_n_s;
    logic                  proc_stall_r, stall_n_s;
    logic                  we_r, we_n_s;
    logic [REG_ADDR_W-1:0] wreg_r, wreg_n_s;
    logic [DATA_W-1:0]     wdata_r, wdata_n_s;
    logic                  err_r, err_n_s;
    logic [PTR_W-1:0]      ptr_r, ptr_n_s;
    logic [CNT_W-1:0]      cnt_r, cnt_n_s;

    logic [NUM_EXT-1:0]    elig_s, grant_s;
    logic [PTR_W-1:0]      rr_next_s;
    logic                  arb_en_s, grant_any_s, prot_ok_s;
    logic [REG_ADDR_W-1:0] sel_reg_s;
    logic [DATA_W-1:0]     sel_data_s;
    wr_src_e               src_s;

    // A requester still showing its ack is mid-release and must not be granted again.
    assign elig_s      = bus.ext_req & ~ext_ack_r;
    assign arb_en_s    = proc_stall_r | ~bus.wb_en;
    assign grant_any_s = |grant_s;

    rr_arbiter #(
        .N     (NUM_EXT),
        .PTR_W (PTR_W)
    ) u_rr (
        .elig     (elig_s),
        .ptr      (ptr_r),
        .en       (arb_en_s),
        .grant    (grant_s),
        .next_ptr (rr_next_s)
    );

    // One-hot grant selects the winning requester's register and data.
    always_comb begin
        sel_reg_s  = '0;
        sel_data_s = '0;
        for (int i = 0; i < NUM_EXT; i++) begin
            if (grant_s[i]) begin
                sel_reg_s  = sel_reg_s  | bus.ext_reg[REG_ADDR_W*i +: REG_ADDR_W];
                sel_data_s = sel_data_s | bus.ext_data[DATA_W*i +: DATA_W];
            end else begin
                sel_reg_s  = sel_reg_s;
                sel_data_s = sel_data_s;
            end
        end
    end

`ifdef REGFILE_ARB_PROTECT_EN
    assign prot_ok_s = EXT_WRITE_MASK[sel_reg_s];
`else
    logic unused_mask_s;
    assign unused_mask_s = ^EXT_WRITE_MASK;
    assign prot_ok_s     = 1'b1;
`endif

    // Owner of the write port for the decision at this edge.
    always_comb begin
        if (grant_any_s) begin
            src_s = SRC_EXT;
        end else if (!proc_stall_r && bus.wb_en) begin
            src_s = SRC_PROC;
        end else begin
            src_s = SRC_IDLE;
        end
    end

    // Next register values: write port mux, pointer and starvation counter.
    always_comb begin
        ack_n_s   = grant_s;
        stall_n_s = 1'b0;
        we_n_s    = 1'b0;
        wreg_n_s  = wreg_r;
        wdata_n_s = wdata_r;
        ptr_n_s   = ptr_r;
        cnt_n_s   = '0;
        err_n_s   = err_r | (proc_stall_r & bus.wb_en)
                          | ((src_s == SRC_EXT) & ~prot_ok_s);
        case (src_s)
            SRC_EXT: begin
                wreg_n_s  = sel_reg_s;
                wdata_n_s = sel_data_s;
                we_n_s    = (sel_reg_s != REG_ZERO) && prot_ok_s;
                ptr_n_s   = rr_next_s;
            end
            SRC_PROC: begin
                wreg_n_s  = bus.wb_reg;
                wdata_n_s = bus.wb_data;
                we_n_s    = (bus.wb_reg != REG_ZERO);
                // Stall lands on the denial that would bring the run to STARVE_LIMIT.
                if (|elig_s) begin
                    if (cnt_r == CNT_LAST) begin
                        stall_n_s = 1'b1;
                        cnt_n_s   = '0;
                    end else begin
                        cnt_n_s = cnt_r + CNT_W'(1);
                    end
                end else begin
                    cnt_n_s = '0;
                end
            end
            SRC_IDLE: begin
                cnt_n_s = '0;
            end
            default: begin
                cnt_n_s = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            ext_ack_r    <= '0;
            proc_stall_r <= 1'b0;
            we_r         <= 1'b0;
            wreg_r       <= '0;
            wdata_r      <= '0;
            err_r        <= 1'b0;
            ptr_r        <= '0;
            cnt_r        <= '0;
        end else begin
            ext_ack_r    <= ack_n_s;
            proc_stall_r <= stall_n_s;
            we_r         <= we_n_s;
            wreg_r       <= wreg_n_s;
            wdata_r      <= wdata_n_s;
            err_r        <= err_n_s;
            ptr_r        <= ptr_n_s;
            cnt_r        <= cnt_n_s;
        end
    end

    assign bus.ext_ack          = ext_ack_r;
    assign bus.proc_stall       = proc_stall_r;
    assign bus.ctrl_writeEnable = we_r;
    assign bus.ctrl_writeReg    = wreg_r;
    assign bus.data_writeReg    = wdata_r;
    assign bus.err_sticky       = err_r;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed scenarios followed by random traffic, all checked against a
// cycle-level behavioural model of the arbitration rules.
module tb_regfile_write_arbiter;

    localparam int N     = 3;
    localparam int LIMIT = 4;
    localparam int RW    = 5 * N;
    localparam int DW    = 32 * N;
`ifdef REGFILE_ARB_PROTECT_EN
    localparam logic [31:0] MASK = 32'h4000_0002;
`endif

    logic clock;
    logic ctrl_reset;
    int   total;
    int   bad;

    logic [31:0] tb_rf [0:31];
    logic [31:0] m_rf  [0:31];
    logic [N-1:0] m_ack;
    logic         m_stall, m_we, m_err;
    logic [4:0]   m_wreg;
    logic [31:0]  m_wdata;
    int           m_cnt, m_ptr;

    regfile_write_arbiter_if #(.NUM_EXT(N)) bus ();

    regfile_write_arbiter #(
        .NUM_EXT      (N),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .bus        (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Regfile stand-in: commits at the negedge inside the cycle.
    always @(negedge clock) begin
        if (bus.ctrl_writeEnable) tb_rf[bus.ctrl_writeReg] <= bus.data_writeReg;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit bit_of(input logic [N-1:0] v, input int i);
        return ((int'(v) >> i) & 1) != 0;
    endfunction

    task automatic set_ext(input int i, input logic [4:0] r, input logic [31:0] d);
        bus.ext_reg  = (bus.ext_reg & ~(RW'(5'h1F) << (5 * i))) | (RW'(r) << (5 * i));
        bus.ext_data = (bus.ext_data & ~(DW'(32'hFFFF_FFFF) << (32 * i))) | (DW'(d) << (32 * i));
        bus.ext_req  = bus.ext_req | (N'(1) << i);
    endtask

    task automatic drop(input int i);
        bus.ext_req = bus.ext_req & ~(N'(1) << i);
    endtask

    task automatic model_reset();
        m_ack = '0; m_stall = 1'b0; m_we = 1'b0; m_err = 1'b0;
        m_wreg = '0; m_wdata = '0; m_cnt = 0; m_ptr = 0;
    endtask

    // One arbitration decision from the rules, using the inputs now on the bus.
    task automatic model_eval();
        int e, win, k;
        logic [4:0] r;
        logic [31:0] d;
        bit ok, next_stall;
        e = int'(bus.ext_req & ~m_ack);
        win = -1;
        r = '0;
        d = '0;
        if (m_stall || !bus.wb_en) begin
            for (int j = 0; j < N; j++) begin
                k = (m_ptr + j) % N;
                if (win < 0 && ((e >> k) & 1) != 0) win = k;
            end
        end
        if (m_stall && bus.wb_en) m_err = 1'b1;
        next_stall = 1'b0;
        if (win >= 0) begin
            r = 5'(bus.ext_reg >> (5 * win));
            d = 32'(bus.ext_data >> (32 * win));
            ok = 1'b1;
`ifdef REGFILE_ARB_PROTECT_EN
            ok = ((MASK >> r) & 32'd1) != 32'd0;
`endif
            if (!ok) m_err = 1'b1;
            m_ack = N'(1) << win;
            m_we = ok && (r != 5'd0);
            m_wreg = r;
            m_wdata = d;
            m_ptr = (win + 1) % N;
            m_cnt = 0;
        end else begin
            m_ack = '0;
            if (!m_stall && bus.wb_en) begin
                m_wreg = bus.wb_reg;
                m_wdata = bus.wb_data;
                m_we = (bus.wb_reg != 5'd0);
                if (e != 0) begin
                    m_cnt++;
                    if (m_cnt == LIMIT) begin
                        next_stall = 1'b1;
                        m_cnt = 0;
                    end
                end else begin
                    m_cnt = 0;
                end
            end else begin
                m_we = 1'b0;
                m_cnt = 0;
            end
        end
        m_stall = next_stall;
        if (m_we) m_rf[m_wreg] = m_wdata;
    endtask

    task automatic step();
        model_eval();
        @(posedge clock);
        #1;
        chk("ext_ack",    64'(bus.ext_ack),          64'(m_ack));
        chk("proc_stall", 64'(bus.proc_stall),       64'(m_stall));
        chk("write_en",   64'(bus.ctrl_writeEnable), 64'(m_we));
        chk("write_reg",  64'(bus.ctrl_writeReg),    64'(m_wreg));
        chk("write_data", 64'(bus.data_writeReg),    64'(m_wdata));
        chk("err_sticky", 64'(bus.err_sticky),       64'(m_err));
        @(negedge clock);
        #1;
        chk("regfile", 64'(tb_rf[m_wreg]), 64'(m_rf[m_wreg]));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"},   64'(bus.ext_ack),          64'd0);
        chk({tag, "_stall"}, 64'(bus.proc_stall),       64'd0);
        chk({tag, "_we"},    64'(bus.ctrl_writeEnable), 64'd0);
        chk({tag, "_reg"},   64'(bus.ctrl_writeReg),    64'd0);
        chk({tag, "_data"},  64'(bus.data_writeReg),    64'd0);
        chk({tag, "_err"},   64'(bus.err_sticky),       64'd0);
    endtask

    initial begin
        int drop_next;
        int sel;
        logic [4:0] r;
        total = 0;
        bad = 0;
        drop_next = 0;
        for (int i = 0; i < 32; i++) begin
            tb_rf[i] = '0;
            m_rf[i] = '0;
        end
        bus.wb_en = 1'b0; bus.wb_reg = '0; bus.wb_data = '0;
        bus.ext_req = '0; bus.ext_reg = '0; bus.ext_data = '0;
        ctrl_reset = 1'b0;
        model_reset();
        #2 ctrl_reset = 1'b1;
        #1 chk_all_zero("reset");
        @(negedge clock);
        #1 ctrl_reset = 1'b0;

        // Round-robin fairness: each requester drops req one cycle after its ack.
        set_ext(0, 5'd1, 32'h0000_0011);
        set_ext(1, 5'd30, 32'h0000_0022);
        set_ext(2, 5'd7, 32'h0000_0033);
        step(); chk("rr_ack0", 64'(bus.ext_ack), 64'd1); chk("rr_reg0", 64'(bus.ctrl_writeReg), 64'd1);
        step(); chk("rr_ack1", 64'(bus.ext_ack), 64'd2); chk("rr_reg1", 64'(bus.ctrl_writeReg), 64'd30);
        drop(0);
        step(); chk("rr_ack2", 64'(bus.ext_ack), 64'd4); chk("rr_rf7", 64'(tb_rf[7]), 64'h33);
        drop(1);
        step(); chk("rr_idle_we", 64'(bus.ctrl_writeEnable), 64'd0);
        drop(2);

        // Processor write wins, the waiting ext write follows on the idle cycle.
        bus.wb_en = 1'b1; bus.wb_reg = 5'd5; bus.wb_data = 32'hDEAD_BEEF;
        set_ext(0, 5'd3, 32'h0000_1234);
        step(); chk("pw_reg", 64'(bus.ctrl_writeReg), 64'd5); chk("pw_ack", 64'(bus.ext_ack), 64'd0);
        bus.wb_en = 1'b0;
        step(); chk("pw_ext_ack", 64'(bus.ext_ack), 64'd1); chk("pw_rf3", 64'(tb_rf[3]), 64'h1234);
        drop(0);

        // Starvation guard, with a processor write presented during the stall.
        set_ext(2, 5'd30, 32'd7);
        for (int c = 0; c < LIMIT; c++) begin
            bus.wb_en = 1'b1; bus.wb_reg = 5'd5; bus.wb_data = 32'(c);
            step();
        end
        chk("sv_stall", 64'(bus.proc_stall), 64'd1);
        bus.wb_reg = 5'd9; bus.wb_data = 32'h0000_0099;
        step();
        chk("sv_ack", 64'(bus.ext_ack), 64'd4);
        chk("sv_rf30", 64'(tb_rf[30]), 64'd7);
        chk("sv_err", 64'(bus.err_sticky), 64'd1);
        chk("sv_drop", 64'(tb_rf[9]), 64'd0);
        drop(2);
        bus.wb_en = 1'b0;

        // r0 write is acked but never reaches the regfile.
        set_ext(0, 5'd0, 32'hFFFF_FFFF);
        step(); chk("r0_ack", 64'(bus.ext_ack), 64'd1); chk("r0_we", 64'(bus.ctrl_writeEnable), 64'd0);
        drop(0);

        // Reset while an ack is showing; the held request is acked again after release.
        set_ext(1, 5'd1, 32'h0000_00AB);
        step(); chk("rm_ack", 64'(bus.ext_ack), 64'd2);
        ctrl_reset = 1'b1;
        #1 chk_all_zero("rm");
        model_reset();
        @(negedge clock);
        #1 ctrl_reset = 1'b0;
        step(); chk("rm_reack", 64'(bus.ext_ack), 64'd2);
        drop(1);

`ifdef REGFILE_ARB_PROTECT_EN
        set_ext(0, 5'd5, 32'h0000_0055);
        step(); chk("pr_ack", 64'(bus.ext_ack), 64'd1);
        chk("pr_we", 64'(bus.ctrl_writeEnable), 64'd0); chk("pr_err", 64'(bus.err_sticky), 64'd1);
        drop(0);
        set_ext(1, 5'd1, 32'h0000_0111);
        step(); chk("pr_rf1", 64'(tb_rf[1]), 64'h111);
        drop(1);
        set_ext(2, 5'd30, 32'h0000_0333);
        step(); chk("pr_rf30", 64'(tb_rf[30]), 64'h333);
        drop(2);
`endif

        // Random traffic under the same rules.
        for (int s = 0; s < 600; s++) begin
            bus.wb_en = m_stall ? 1'b0 : ($urandom_range(9) < 6);
            bus.wb_reg = 5'($urandom);
            bus.wb_data = $urandom;
            for (int i = 0; i < N; i++) begin
                if (((drop_next >> i) & 1) != 0) begin
                    drop(i);
                    drop_next = drop_next & ~(1 << i);
                end else if (bit_of(m_ack, i)) begin
                    if ($urandom_range(1) == 0) drop(i);
                    else drop_next = drop_next | (1 << i);
                end else if (bit_of(bus.ext_req, i)) begin
                    if ($urandom_range(19) == 0) drop(i);
                end else if ($urandom_range(2) == 0) begin
                    sel = int'($urandom_range(4));
                    case (sel)
                        0: r = 5'd0;
                        1: r = 5'd1;
                        2: r = 5'd5;
                        3: r = 5'd30;
                        default: r = 5'($urandom);
                    endcase
                    set_ext(i, r, $urandom);
                end
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
